// File: rtl/addlist_sched_pkg.sv
// rtl/addlist_sched_pkg.sv - shared types and constants for the addlist scheduler
package addlist_pkg;

  typedef logic [31:0] float32_t;

  localparam float32_t FP_ZERO      = 32'h0;
  localparam int       DEF_BUF_SIZE = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FILL,
    ISSUE,
    DRAIN,
    RESP
  } sched_state_t;

endpackage

// File: rtl/addlist_sched_if.sv
// rtl/addlist_sched_if.sv - requester, result and addlist-side signal bundle
interface addlist_sched_if
  import addlist_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int BUF_SIZE = DEF_BUF_SIZE,
  parameter int ID_W     = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0][31:0]  req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      res_valid;
  float32_t                  res_data;
  logic [ID_W-1:0]           res_id;
  logic [15:0]               res_count;
  logic                      res_ready;

  logic                      add_rst;
  float32_t [BUF_SIZE-1:0]   add_buf;
  logic                      add_provided;
  logic                      add_requested;
  logic                      add_result_available;
  float32_t                  add_result;

  modport master (
    input  req_valid, req_data, req_last, res_ready,
           add_requested, add_result_available, add_result,
    output req_ready, res_valid, res_data, res_id, res_count,
           add_rst, add_buf, add_provided
  );

  modport slave (
    output req_valid, req_data, req_last, res_ready,
           add_requested, add_result_available, add_result,
    input  req_ready, res_valid, res_data, res_id, res_count,
           add_rst, add_buf, add_provided
  );

endinterface

// File: rtl/addlist_sched_rr_arbiter.sv
// rtl/addlist_sched_rr_arbiter.sv - round-robin pick with pointer advanced past the finished job
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               done,
  input  logic [ID_W-1:0]    done_id,
  output logic               any,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    any      = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        any      = 1'b1;
        grant_id = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (done) begin
      ptr <= (done_id == ID_W'(NUM_REQ - 1)) ? '0 : done_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/addlist_sched.sv
// rtl/addlist_sched.sv - shares one addlist list-adder between round-robin requesters
module addlist_sched
  import addlist_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int BUF_SIZE = DEF_BUF_SIZE,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst,
  addlist_sched_if.master bus
);

  localparam int IDX_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;

  sched_state_t            state, next_state;
  logic [ID_W-1:0]         grant, arb_id;
  logic                    arb_any, done, accept, last_batch, add_rst_q;
  logic [IDX_W-1:0]        ptr;
  logic [15:0]             count;
  float32_t [BUF_SIZE-1:0] buf_q;
  float32_t                res_data_q;
  logic [NUM_REQ-1:0]      ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .done      (done),
    .done_id   (grant),
    .any       (arb_any),
    .grant_id  (arb_id)
  );

  assign accept = (state == FILL) && bus.req_valid[grant];

  always_comb begin
    next_state = state;
    done       = 1'b0;
    case (state)
      IDLE:  if (arb_any) next_state = CLR;
      CLR:   next_state = FILL;
      FILL:  if (accept && (ptr == IDX_W'(BUF_SIZE - 1) || bus.req_last[grant]))
               next_state = ISSUE;
      ISSUE: if (bus.add_requested) next_state = last_batch ? DRAIN : FILL;
      DRAIN: if (bus.add_requested && bus.add_result_available) next_state = RESP;
      RESP:  if (bus.res_ready) begin
               next_state = IDLE;
               done       = 1'b1;
             end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready        = '0;
    ready[grant] = (state == FILL);
  end

  // add_rst is registered so the adder sees a clean one-cycle clear aligned with CLR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      ptr        <= '0;
      count      <= '0;
      buf_q      <= '0;
      last_batch <= 1'b0;
      res_data_q <= FP_ZERO;
      add_rst_q  <= 1'b0;
    end else begin
      state     <= next_state;
      add_rst_q <= (next_state != CLR);
      case (state)
        IDLE: if (arb_any) grant <= arb_id;
        CLR: begin
          ptr        <= '0;
          count      <= '0;
          buf_q      <= '0;
          last_batch <= 1'b0;
        end
        FILL: if (accept) begin
          buf_q[ptr] <= bus.req_data[grant];
          ptr        <= ptr + IDX_W'(1);
          if (count != 16'hFFFF) count <= count + 16'd1;
          last_batch <= bus.req_last[grant];
        end
        ISSUE: if (bus.add_requested) begin
          buf_q <= '0;
          ptr   <= '0;
        end
        DRAIN: if (bus.add_requested && bus.add_result_available)
          res_data_q <= bus.add_result;
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = ready;
  assign bus.add_provided = (state == ISSUE);
  assign bus.add_buf      = buf_q;
  assign bus.add_rst      = add_rst_q;
  assign bus.res_valid    = (state == RESP);
  assign bus.res_data     = res_data_q;
  assign bus.res_id       = grant;
  assign bus.res_count    = count;

endmodule

// File: tb/tb_addlist_sched.sv
// tb/tb_addlist_sched.sv - directed self-checking bench for addlist_sched
module tb_addlist_sched;
  import addlist_pkg::*;

  localparam int NR = 4;
  localparam int BS = 4;

  logic                clk;
  logic                rst;
  logic [31:0]         sum_val;
  int                  checks = 0;
  int                  errors = 0;
  int                  clr_cycles = 0;
  int                  base;
  int                  cbase;
  logic [BS*32-1:0]    batches[$];

  addlist_sched_if #(.NUM_REQ(NR), .BUF_SIZE(BS)) bus();

  addlist_sched #(.NUM_REQ(NR), .BUF_SIZE(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.add_result = sum_val;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.add_provided && bus.add_requested) batches.push_back(bus.add_buf);
      if (!bus.add_rst) clr_cycles++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [1:0] r, input logic [31:0] w, input logic last);
    int n = 0;
    bus.req_valid[r] = 1'b1;
    bus.req_data[r]  = w;
    bus.req_last[r]  = last;
    while (bus.req_ready[r] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_r%0d", r), 128'(bus.req_ready[r]), 128'(1'b1));
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
    bus.req_last[r]  = 1'b0;
  endtask

  task automatic wait_grant(input logic [3:0] mask, input string tag);
    int n = 0;
    while (bus.req_ready === 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(bus.req_ready), 128'(mask));
  endtask

  task automatic wait_res(input logic [31:0] d, input logic [1:0] id,
                          input logic [15:0] cnt, input int hold);
    int n = 0;
    while (bus.res_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid", 128'(bus.res_valid), 128'(1'b1));
    chk("res_data", 128'(bus.res_data), 128'(d));
    chk("res_id", 128'(bus.res_id), 128'(id));
    chk("res_count", 128'(bus.res_count), 128'(cnt));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(bus.res_valid), 128'(1'b1));
      chk("hold_data", 128'(bus.res_data), 128'(d));
      chk("hold_no_grant", 128'(bus.req_ready), 128'(4'b0));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_done", 128'(bus.res_valid), 128'(1'b0));
  endtask

  initial begin
    rst                      = 1'b0;
    sum_val                  = 32'h0;
    bus.req_valid            = '0;
    bus.req_data             = '0;
    bus.req_last             = '0;
    bus.res_ready            = 1'b0;
    bus.add_requested        = 1'b1;
    bus.add_result_available = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", 128'(bus.req_ready), 128'(4'b0));
    chk("rst_res_valid", 128'(bus.res_valid), 128'(1'b0));
    chk("rst_res_data", 128'(bus.res_data), 128'(32'h0));
    chk("rst_res_id", 128'(bus.res_id), 128'(2'd0));
    chk("rst_res_count", 128'(bus.res_count), 128'(16'h0));
    chk("rst_add_rst", 128'(bus.add_rst), 128'(1'b0));
    chk("rst_add_buf", 128'(bus.add_buf), 128'(0));
    chk("rst_add_provided", 128'(bus.add_provided), 128'(1'b0));

    rst = 1'b1;
    repeat (3) @(negedge clk);

    // One full batch from requester 0: 1+2+3+4 = 10.0
    base = batches.size(); cbase = clr_cycles; sum_val = 32'h41200000;
    send_word(2'd0, 32'h3F800000, 1'b0);
    send_word(2'd0, 32'h40000000, 1'b0);
    send_word(2'd0, 32'h40400000, 1'b0);
    send_word(2'd0, 32'h40800000, 1'b1);
    wait_res(32'h41200000, 2'd0, 16'd4, 0);
    chk("j1_batches", 128'(batches.size() - base), 128'(1));
    chk("j1_buf", batches[base], {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
    chk("j1_clr_cycles", 128'(clr_cycles - cbase), 128'(1));
    chk("j1_buf_zeroed", 128'(bus.add_buf), 128'(0));

    // Single word from requester 1, padded with +0.0
    base = batches.size(); sum_val = 32'h3FC00000;
    send_word(2'd1, 32'h3FC00000, 1'b1);
    wait_res(32'h3FC00000, 2'd1, 16'd1, 0);
    chk("j2_batches", 128'(batches.size() - base), 128'(1));
    chk("j2_buf", batches[base], {32'h0, 32'h0, 32'h0, 32'h3FC00000});

    // Five words of 1.0 from requester 0 -> two batches, one clear
    base = batches.size(); cbase = clr_cycles; sum_val = 32'h40A00000;
    for (int i = 0; i < 5; i++) send_word(2'd0, 32'h3F800000, (i == 4));
    wait_res(32'h40A00000, 2'd0, 16'd5, 0);
    chk("j3_batches", 128'(batches.size() - base), 128'(2));
    chk("j3_buf0", batches[base], {4{32'h3F800000}});
    chk("j3_buf1", batches[base+1], {32'h0, 32'h0, 32'h0, 32'h3F800000});
    chk("j3_clr_cycles", 128'(clr_cycles - cbase), 128'(1));

    // Reset while ISSUE is stalled, then rerun the same job
    bus.add_requested = 1'b0; sum_val = 32'h41200000;
    send_word(2'd0, 32'h3F800000, 1'b0);
    send_word(2'd0, 32'h40000000, 1'b0);
    send_word(2'd0, 32'h40400000, 1'b0);
    send_word(2'd0, 32'h40800000, 1'b1);
    chk("issue_provided", 128'(bus.add_provided), 128'(1'b1));
    chk("issue_buf", 128'(bus.add_buf), {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
    #2 rst = 1'b0;
    #1;
    chk("abort_provided", 128'(bus.add_provided), 128'(1'b0));
    chk("abort_req_ready", 128'(bus.req_ready), 128'(4'b0));
    chk("abort_res_valid", 128'(bus.res_valid), 128'(1'b0));
    chk("abort_add_rst", 128'(bus.add_rst), 128'(1'b0));
    chk("abort_add_buf", 128'(bus.add_buf), 128'(0));
    @(negedge clk);
    rst = 1'b1; bus.add_requested = 1'b1;
    repeat (2) @(negedge clk);
    base = batches.size();
    send_word(2'd0, 32'h3F800000, 1'b0);
    send_word(2'd0, 32'h40000000, 1'b0);
    send_word(2'd0, 32'h40400000, 1'b0);
    send_word(2'd0, 32'h40800000, 1'b1);
    wait_res(32'h41200000, 2'd0, 16'd4, 0);
    chk("restart_batches", 128'(batches.size() - base), 128'(1));

    // Contention between requesters 0 and 2 from a fresh pointer
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sum_val = 32'h40000000;
    bus.req_valid[0] = 1'b1; bus.req_data[0] = 32'h40000000; bus.req_last[0] = 1'b1;
    bus.req_valid[2] = 1'b1; bus.req_data[2] = 32'h40400000; bus.req_last[2] = 1'b1;
    wait_grant(4'b0001, "grant_first_req0");
    @(negedge clk);
    bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0;
    wait_res(32'h40000000, 2'd0, 16'd1, 0);

    sum_val = 32'h40400000;
    bus.req_valid[0] = 1'b1; bus.req_data[0] = 32'h3F800000; bus.req_last[0] = 1'b1;
    wait_grant(4'b0100, "grant_req2_after_req0");
    @(negedge clk);
    bus.req_valid[2] = 1'b0; bus.req_last[2] = 1'b0;
    wait_res(32'h40400000, 2'd2, 16'd1, 10);

    sum_val = 32'h3F800000;
    wait_grant(4'b0001, "grant_req0_after_req2");
    @(negedge clk);
    bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0;
    wait_res(32'h3F800000, 2'd0, 16'd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
